control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
// - Multi-cycle fetch/decode/execute sequencer for the tiny16 core, directly upstream of the register file.
// - Fetches a 16-bit instruction from memory at the address in r0 (the PC) and latches it in an internal IR.
// - Decodes the IR and drives the register file's src_sel, dst_sel, in_en, out_en and pc_inc.
// - Also drives the ALU opcode and the memory read/write strobes.
// PARAMETERS
// - OPW  4  opcode field width; the opcode occupies IR[15:12].
// - RSW  3  register select width; dst = IR[11:9], src = IR[8:6].
// PORTS
// - clk        in   1   system clock; all state changes on posedge.
// - rst        in   1   asynchronous, active-high reset.
// - mem_data   in   16  instruction/data read bus.
// - mem_ready  in   1   memory completes the current mem_rd/mem_wr this cycle.
// - step       in   1   single-step pulse (used only with CTRL_STEP_EN).
// - src_sel    out  3   register file source select.
// - dst_sel    out  3   register file destination select.
// - in_en      out  1   register file write enable (rf writes on negedge).
// - out_en     out  1   register file drives its out bus with gpr[src_sel].
// - pc_inc     out  1   increment r0.
// - alu_op     out  3   0 PASS, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR.
// - mem_rd     out  1   memory read request.
// - mem_wr     out  1   memory write request.
// - halted     out  1   core is stopped in HALT.
// - illegal    out  1   sticky flag: an undefined opcode was decoded.
// BEHAVIOUR
// - Reset (async): state=FETCH, IR=0, illegal=0. Every output is 0 while rst is high and in the first cycle after.
// - FETCH: src_sel=0, out_en=1, mem_rd=1. Hold until mem_ready=1.
//   - On ready: IR<=mem_data, pc_inc=1 for exactly that one cycle, then go to DECODE.
// - DECODE: src_sel=IR[8:6], dst_sel=IR[11:9]. These are held from here through the end of the instruction.
//   - The rf registers src/dst at the next edge, so there is 1 cycle of operand latency. Go to EXEC.
// - EXEC, by opcode:
//   - 0 NOP: go to FETCH.
//   - 1 MOV / 2 ADD / 3 SUB / 4 AND / 5 OR / 6 XOR: alu_op = PASS/ADD/SUB/AND/OR/XOR; go to WB.
//   - 7 LD: out_en=1, mem_rd=1 (address = gpr[src]). Wait for mem_ready.
//     - On ready: in_en=1 for one cycle (dst <= mem_data), then go to FETCH.
//   - 8 ST: mem_wr=1 (address = gpr[dst], data = gpr[src] on the out bus via out_en=1). Wait for mem_ready, then go to FETCH.
//   - F HLT: go to HALT.
//   - 9..E: illegal<=1; treat as NOP.
// - WB: in_en=1 for exactly one cycle with alu_op held; go to FETCH.
//   - Instruction latency: ALU op = 4 cycles + fetch wait states.
// - HALT: halted=1; all strobes 0. Only reset exits HALT.
// - Writing r0 (dst=0) is a jump.
//   - pc_inc and in_en are never asserted in the same cycle, so the rf never sees an increment/write collision on r0.
// - mem_rd and mem_wr are mutually exclusive. Each is held stable until mem_ready; no timeout.
// - Reset asserted mid-instruction aborts it immediately. Any half-written state is discarded; restart from FETCH.
// - Exactly one state is active at a time; unreachable encodings return to FETCH.
// CONFIGURATION
// - CTRL_STEP_EN defined:
//   - After each instruction completes, the FSM waits in a STEP state with halted=1.
//   - A 1-cycle step pulse releases it to FETCH. A step held high advances exactly one instruction per rising edge of step.
// - CTRL_STEP_EN undefined: no STEP state; the step input is ignored; the FSM runs freely.
// TESTING
// - Reset: rst pulse mid-FETCH -> all outputs 0, state FETCH, illegal=0.
// - Fetch: next cycle -> src_sel=0, out_en=1, mem_rd=1.
// - Wait states: mem_ready low 3 cycles -> mem_rd held 3 cycles, then IR loads and pc_inc=1 for 1 cycle.
// - ADD: IR=0x2A40 (ADD r5,r1) -> DECODE dst_sel=5, src_sel=1; EXEC alu_op=1; WB in_en=1 for 1 cycle; 4 cycles total.
// - LD: IR=0x7480 (LD r2,[r2]) -> mem_rd+out_en until ready, then in_en=1 with dst_sel=2; pc_inc never high alongside in_en.
// - ST then HLT: IR=0x8640 -> mem_wr=1 until ready. Next IR=0xF000 -> halted=1 forever; rst exits.
// - Illegal: IR=0xB000 -> illegal=1 sticky, no in_en, next FETCH.
// - CTRL_STEP_EN: each step pulse executes exactly one MOV.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer for the tiny16 core.
// Drives the register file selects/strobes, the ALU opcode and memory strobes.
// Optional feature macro: CTRL_STEP_EN (single-step; parks in STEP with
// halted=1 after every instruction until a rising edge on step).
module control_unit #(
  parameter int OPW = 4,
  parameter int RSW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [15:0]    mem_data,
  input  logic           mem_ready,
  input  logic           step,
  output logic [RSW-1:0] src_sel,
  output logic [RSW-1:0] dst_sel,
  output logic           in_en,
  output logic           out_en,
  output logic           pc_inc,
  output logic [2:0]     alu_op,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic           halted,
  output logic           illegal
);

  // Only opcode, dst and src fields of the instruction are ever used.
  localparam int IRW = OPW + 2*RSW;

  localparam logic [OPW-1:0] OP_NOP = OPW'(0);
  localparam logic [OPW-1:0] OP_MOV = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3);
  localparam logic [OPW-1:0] OP_AND = OPW'(4);
  localparam logic [OPW-1:0] OP_OR  = OPW'(5);
  localparam logic [OPW-1:0] OP_XOR = OPW'(6);
  localparam logic [OPW-1:0] OP_LD  = OPW'(7);
  localparam logic [OPW-1:0] OP_ST  = OPW'(8);
  localparam logic [OPW-1:0] OP_HLT = OPW'(15);

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_XOR  = 3'd5;

`ifdef CTRL_STEP_EN
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_WB = 3'd3,
    S_HALT = 3'd4, S_STEP = 3'd5
  } state_t;
  localparam state_t S_DONE = S_STEP;
`else
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_WB = 3'd3,
    S_HALT = 3'd4
  } state_t;
  localparam state_t S_DONE = S_FETCH;
`endif

  state_t           state_q, state_d;
  logic [IRW-1:0]   ir_q, ir_d;
  logic             illegal_q, illegal_d;
  logic [RSW-1:0]   src_sel_q, src_sel_d, dst_sel_q, dst_sel_d;
  logic             out_en_q, out_en_d, mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             wb_q, wb_d, halted_q, halted_d;
`ifdef CTRL_STEP_EN
  logic             step_prev_q;
`endif

  logic [OPW-1:0]   op_q, op_d;
  logic [RSW-1:0]   dst_d, src_d;
  logic             fetch_hs, mem_hs;

  assign op_q  = ir_q[IRW-1 -: OPW];
  assign op_d  = ir_d[IRW-1 -: OPW];
  assign dst_d = ir_d[2*RSW-1 -: RSW];
  assign src_d = ir_d[RSW-1:0];

  // Handshakes only count once the registered request is actually on the bus.
  assign fetch_hs = (state_q == S_FETCH) && mem_rd_q && mem_ready;
  assign mem_hs   = (state_q == S_EXEC) && (mem_rd_q || mem_wr_q) && mem_ready;

  function automatic logic is_alu(input logic [OPW-1:0] op);
    return (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR);
  endfunction

  function automatic logic [2:0] alu_of(input logic [OPW-1:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      default: return ALU_PASS;
    endcase
  endfunction

  // Next-state, IR capture and sticky illegal-opcode flag.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: if (fetch_hs) begin
        ir_d    = mem_data[15 -: IRW];
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (op_q == OP_NOP)            state_d = S_DONE;
        else if (is_alu(op_q))         state_d = S_WB;
        else if (op_q == OP_LD || op_q == OP_ST) begin
          if (mem_hs)                  state_d = S_DONE;
        end
        else if (op_q == OP_HLT)       state_d = S_HALT;
        else begin
          illegal_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_WB:   state_d = S_DONE;
      S_HALT: state_d = S_HALT;
`ifdef CTRL_STEP_EN
      S_STEP: if (step && !step_prev_q) state_d = S_FETCH;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Registered outputs: decoded from the state being entered so they line up
  // with state_q in the following cycle.
  always_comb begin
    src_sel_d = '0;
    dst_sel_d = '0;
    out_en_d  = 1'b0;
    mem_rd_d  = 1'b0;
    mem_wr_d  = 1'b0;
    alu_op_d  = ALU_PASS;
    wb_d      = 1'b0;
    halted_d  = 1'b0;
    case (state_d)
      S_FETCH: begin
        out_en_d = 1'b1;
        mem_rd_d = 1'b1;
      end
      S_DECODE: begin
        src_sel_d = src_d;
        dst_sel_d = dst_d;
      end
      S_EXEC: begin
        src_sel_d = src_d;
        dst_sel_d = dst_d;
        if (is_alu(op_d)) alu_op_d = alu_of(op_d);
        if (op_d == OP_LD) begin
          out_en_d = 1'b1;
          mem_rd_d = 1'b1;
        end
        if (op_d == OP_ST) begin
          out_en_d = 1'b1;
          mem_wr_d = 1'b1;
        end
      end
      S_WB: begin
        src_sel_d = src_d;
        dst_sel_d = dst_d;
        alu_op_d  = alu_of(op_d);
        wb_d      = 1'b1;
      end
      S_HALT: halted_d = 1'b1;
`ifdef CTRL_STEP_EN
      S_STEP: halted_d = 1'b1;
`endif
      default: ;
    endcase
  end

  // State, IR and output registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      src_sel_q <= '0;
      dst_sel_q <= '0;
      out_en_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      alu_op_q  <= ALU_PASS;
      wb_q      <= 1'b0;
      halted_q  <= 1'b0;
`ifdef CTRL_STEP_EN
      step_prev_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      src_sel_q <= src_sel_d;
      dst_sel_q <= dst_sel_d;
      out_en_q  <= out_en_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      alu_op_q  <= alu_op_d;
      wb_q      <= wb_d;
      halted_q  <= halted_d;
`ifdef CTRL_STEP_EN
      step_prev_q <= step;
`endif
    end
  end

  // pc_inc and the LD write strobe qualify with mem_ready in the completing
  // cycle so r0 bumps with the IR load and the rf captures mem_data while
  // it is still valid. They live in different states, so never collide.
  assign pc_inc  = fetch_hs;
  assign in_en   = wb_q | (mem_hs & mem_rd_q);
  assign src_sel = src_sel_q;
  assign dst_sel = dst_sel_q;
  assign out_en  = out_en_q;
  assign mem_rd  = mem_rd_q;
  assign mem_wr  = mem_wr_q;
  assign alu_op  = alu_op_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;

  // Instruction bits below the src field carry no meaning for sequencing.
  logic unused_in;
`ifdef CTRL_STEP_EN
  assign unused_in = ^mem_data[15-IRW:0];
`else
  assign unused_in = ^{mem_data[15-IRW:0], step};
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized instruction stream against a per-instruction
// cycle-trace model of the tiny16 sequencer, plus literal spot checks.
module tb_control_unit;

  typedef struct packed {
    logic [2:0] src;
    logic [2:0] dst;
    logic       in_en;
    logic       out_en;
    logic       pc_inc;
    logic [2:0] alu;
    logic       rd;
    logic       wr;
    logic       halted;
    logic       illegal;
  } out_t;

  logic        clk = 1'b0, rst = 1'b1, mem_ready = 1'b0, step = 1'b0;
  logic [15:0] mem_data = '0;
  logic [2:0]  src_sel, dst_sel, alu_op;
  logic        in_en, out_en, pc_inc, mem_rd, mem_wr, halted, illegal;

  int    total = 0, passed = 0, ncyc = 0;
  logic  ill = 1'b0;
  string lbl = "init";
  out_t  hist[$];

  always #5 clk = ~clk;

  control_unit #(.OPW(4), .RSW(3)) dut (
    .clk(clk), .rst(rst), .mem_data(mem_data), .mem_ready(mem_ready),
    .step(step), .src_sel(src_sel), .dst_sel(dst_sel), .in_en(in_en),
    .out_en(out_en), .pc_inc(pc_inc), .alu_op(alu_op), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .halted(halted), .illegal(illegal)
  );

  function automatic out_t mk(input logic [2:0] s, input logic [2:0] d,
                              input logic ie, input logic oe, input logic pi,
                              input logic [2:0] a, input logic r,
                              input logic w, input logic h);
    out_t o;
    o.src = s; o.dst = d; o.in_en = ie; o.out_en = oe; o.pc_inc = pi;
    o.alu = a; o.rd = r; o.wr = w; o.halted = h; o.illegal = ill;
    return o;
  endfunction

  function automatic out_t e_fetch(input logic pi);
    return mk(3'd0, 3'd0, 1'b0, 1'b1, pi, 3'd0, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic out_t e_halt();
    return mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic out_t e_zero();
    return mk(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  // In free-running builds step must be ignored, so it is driven as noise.
  function automatic logic snoise();
`ifdef CTRL_STEP_EN
    return 1'b0;
`else
    return 1'($urandom);
`endif
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic logic [15:0] rword();
    return 16'($urandom);
  endfunction

  // One clock: drive inputs after the edge, compare all outputs mid-cycle.
  task automatic cyc(input logic r, input logic rdy, input logic [15:0] dat,
                     input logic stp, input out_t e);
    out_t a;
    @(posedge clk); #1;
    rst = r; mem_ready = rdy; mem_data = dat; step = stp;
    @(negedge clk);
    a = {src_sel, dst_sel, in_en, out_en, pc_inc, alu_op, mem_rd, mem_wr,
         halted, illegal};
    hist.push_back(a);
    ncyc++;
    total++;
    if (a === e) passed++;
    else $display("FAIL %s cyc%0d got=%h exp=%h", lbl, ncyc, a, e);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
  endtask

  task automatic do_reset();
    ill = 1'b0;
    cyc(1'b1, 1'b1, rword(), snoise(), e_zero());
    cyc(1'b1, 1'b1, rword(), snoise(), e_zero());
    cyc(1'b0, 1'b1, rword(), snoise(), e_zero());
  endtask

  // Expected trace of one instruction: fetch with fw wait states, decode,
  // execute (mw wait states for LD/ST), optional write-back, optional STEP.
  task automatic do_instr(input logic [15:0] ir, input int fw, input int mw);
    logic [3:0] op;
    logic [2:0] d, s, a;
    op = ir[15:12]; d = ir[11:9]; s = ir[8:6];
    hist.delete();
    for (int i = 0; i < fw; i++) cyc(1'b0, 1'b0, rword(), snoise(), e_fetch(1'b0));
    cyc(1'b0, 1'b1, ir, snoise(), e_fetch(1'b1));
    cyc(1'b0, rbit(), rword(), snoise(), mk(s, d, 0, 0, 0, 3'd0, 0, 0, 0));
    if (op >= 4'd1 && op <= 4'd6) begin
      a = 3'(op - 4'd1);
      cyc(1'b0, rbit(), rword(), snoise(), mk(s, d, 0, 0, 0, a, 0, 0, 0));
      cyc(1'b0, rbit(), rword(), snoise(), mk(s, d, 1, 0, 0, a, 0, 0, 0));
    end else if (op == 4'd7) begin
      for (int i = 0; i < mw; i++)
        cyc(1'b0, 1'b0, rword(), snoise(), mk(s, d, 0, 1, 0, 3'd0, 1, 0, 0));
      cyc(1'b0, 1'b1, rword(), snoise(), mk(s, d, 1, 1, 0, 3'd0, 1, 0, 0));
    end else if (op == 4'd8) begin
      for (int i = 0; i < mw; i++)
        cyc(1'b0, 1'b0, rword(), snoise(), mk(s, d, 0, 1, 0, 3'd0, 0, 1, 0));
      cyc(1'b0, 1'b1, rword(), snoise(), mk(s, d, 0, 1, 0, 3'd0, 0, 1, 0));
    end else begin
      cyc(1'b0, rbit(), rword(), snoise(), mk(s, d, 0, 0, 0, 3'd0, 0, 0, 0));
      if (op >= 4'd9 && op <= 4'd14) ill = 1'b1;
    end
`ifdef CTRL_STEP_EN
    if (op != 4'hF) begin
      int k;
      k = $urandom_range(1, 3);
      for (int i = 0; i < k; i++) cyc(1'b0, rbit(), rword(), 1'b0, e_halt());
      cyc(1'b0, rbit(), rword(), 1'b1, e_halt());
    end
`endif
  endtask

  initial begin
    // Reset state and first cycle after release.
    lbl = "reset";
    do_reset();

    // ADD r5,r1 with no wait states.
    lbl = "add";
    do_instr(16'h2A40, 0, 0);
    chk("add_pc_inc",  int'(hist[0].pc_inc), 1);
    chk("add_dst",     int'(hist[1].dst), 5);
    chk("add_src",     int'(hist[1].src), 1);
    chk("add_alu",     int'(hist[2].alu), 1);
    chk("add_wb",      int'(hist[3].in_en), 1);
    chk("add_wb_alu",  int'(hist[3].alu), 1);

    // LD r2,[r2] with 3 fetch wait states and 2 memory wait states.
    lbl = "ld";
    do_instr(16'h7480, 3, 2);
    chk("ld_wait_rd",  int'(hist[2].rd), 1);
    chk("ld_wait_pc",  int'(hist[2].pc_inc), 0);
    chk("ld_fetch_pc", int'(hist[3].pc_inc), 1);
    chk("ld_mem_rd",   int'(hist[5].rd & hist[5].out_en), 1);
    chk("ld_wait_in",  int'(hist[5].in_en), 0);
    chk("ld_in_en",    int'(hist[7].in_en), 1);
    chk("ld_dst",      int'(hist[7].dst), 2);
    chk("ld_no_pc",    int'(hist[7].pc_inc), 0);

    // Illegal opcode: no write, sticky flag visible from the next fetch on.
    lbl = "illegal";
    do_instr(16'hB000, 0, 0);
    chk("ill_no_in_en", int'(hist[2].in_en), 0);
    lbl = "nop";
    do_instr(16'h0000, 1, 0);
    chk("ill_sticky",  int'(hist[0].illegal), 1);
    chk("ill_fetch",   int'(hist[0].rd), 1);

    // Random legal/illegal stream with random wait states (no HLT).
    lbl = "rand";
    for (int n = 0; n < 80; n++)
      do_instr({4'($urandom_range(0, 14)), 12'($urandom)},
               $urandom_range(0, 3), $urandom_range(0, 3));

    // Reset asserted in the middle of a fetch wait.
    lbl = "rst_mid";
    cyc(1'b0, 1'b0, rword(), snoise(), e_fetch(1'b0));
    hist.delete();
    do_reset();
    chk("rst_illegal", int'(hist[0].illegal), 0);
    chk("rst_rd",      int'(hist[0].rd), 0);

    // ST then HLT: halted until reset, regardless of ready/step.
    lbl = "st";
    do_instr(16'h8640, 1, 3);
    chk("st_wr",    int'(hist[3].wr), 1);
    chk("st_no_in", int'(hist[5].in_en), 0);
    lbl = "hlt";
    do_instr(16'hF000, 0, 0);
    for (int i = 0; i < 10; i++)
      cyc(1'b0, rbit(), rword(), (i % 2 == 1) ? 1'b1 : 1'b0, e_halt());
    chk("hlt_halted", int'(hist[hist.size()-1].halted), 1);
    lbl = "rst_hlt";
    do_reset();
    lbl = "add2";
    do_instr(16'h2A40, 2, 0);
    chk("post_hlt_wb", int'(hist[5].in_en), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
